// File: rtl/cam_pkg.sv
// Shared defaults, bundle types and helpers for the parametrised CAM.
// Optional ternary search is enabled with CAM_TERNARY_EN.
package cam_pkg;

    localparam int CAM_DATA_W    = 32;
    localparam int CAM_DEPTH     = 32;
    localparam int CAM_IDX_W     = $clog2(CAM_DEPTH);
    localparam int CAM_MAX_DEPTH = 1024;

    typedef struct packed {
        logic                  enable;
        logic [CAM_IDX_W-1:0]  index;
        logic [CAM_DATA_W-1:0] data;
    } cam_req_t;

    typedef struct packed {
        logic                 valid;
        logic [CAM_IDX_W-1:0] index;
        logic                 multi;
    } cam_rsp_t;

    // Scans downwards so the last hit kept is the lowest index.
    function automatic int cam_lsb_idx(
        input logic [CAM_MAX_DEPTH-1:0] vec
    );
        int r;
        r = 0;
        for (int i = CAM_MAX_DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Match-vector priority encoder: any hit, lowest hit index, multi-hit.
// Purely combinational; outputs are registered by the caller.
module cam_prio_enc
    import cam_pkg::*;
#(
    parameter int DEPTH = CAM_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] i_match,
    output logic             o_any,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_multi
);

    assign o_any   = |i_match;
    assign o_idx   = IDX_W'(cam_lsb_idx(CAM_MAX_DEPTH'(i_match)));
    // Clearing the lowest set bit leaves something iff two or more hits.
    assign o_multi = |(i_match & (i_match - DEPTH'(1)));

endmodule

// File: rtl/cam_param.sv
// Parametrised CAM with valid bits, invalidate, multi-match and occupancy.
// Define CAM_TERNARY_EN to add the search_mask_i don't-care port.
module cam_param
    import cam_pkg::*;
#(
    parameter int DATA_W = CAM_DATA_W,
    parameter int DEPTH  = CAM_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              read_enable_i,
    input  logic [IDX_W-1:0]  read_index_i,
    input  logic              write_enable_i,
    input  logic [IDX_W-1:0]  write_index_i,
    input  logic [DATA_W-1:0] write_data_i,
    input  logic              inval_enable_i,
    input  logic [IDX_W-1:0]  inval_index_i,
    input  logic              search_enable_i,
    input  logic [DATA_W-1:0] search_data_i,
`ifdef CAM_TERNARY_EN
    input  logic [DATA_W-1:0] search_mask_i,
`endif
    output logic              read_valid_o,
    output logic [DATA_W-1:0] read_value_o,
    output logic              search_valid_o,
    output logic [IDX_W-1:0]  search_index_o,
    output logic              search_multi_o,
    output logic [IDX_W:0]    count_o
);

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  w_valid_nxt;
    logic [DEPTH-1:0]  w_match;
    logic [DATA_W-1:0] w_mask;
    logic              w_inc;
    logic              w_dec;
    logic              w_any;
    logic              w_multi;
    logic [IDX_W-1:0]  w_idx;

`ifdef CAM_TERNARY_EN
    assign w_mask = search_mask_i;
`else
    assign w_mask = '0;
`endif

    always_comb begin
        w_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = r_valid[i] &&
                (((r_data[i] ^ search_data_i) & ~w_mask) == '0);
        end
    end

    cam_prio_enc #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_enc (
        .i_match (w_match),
        .o_any   (w_any),
        .o_idx   (w_idx),
        .o_multi (w_multi)
    );

    // Invalidate first so a same-index write wins.
    always_comb begin
        w_valid_nxt = r_valid;
        if (inval_enable_i) begin
            w_valid_nxt[inval_index_i] = 1'b0;
        end
        if (write_enable_i) begin
            w_valid_nxt[write_index_i] = 1'b1;
        end
    end

    assign w_inc = write_enable_i && !r_valid[write_index_i];
    assign w_dec = inval_enable_i && r_valid[inval_index_i] &&
                   !(write_enable_i && (write_index_i == inval_index_i));

    always_ff @(posedge clk_i) begin
        if (write_enable_i) begin
            r_data[write_index_i] <= write_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= '0;
            count_o <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            count_o <= count_o + (IDX_W+1)'(w_inc)
                               - (IDX_W+1)'(w_dec);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            read_valid_o <= 1'b0;
            read_value_o <= '0;
        end else if (read_enable_i) begin
            read_valid_o <= r_valid[read_index_i];
            read_value_o <= r_valid[read_index_i] ?
                            r_data[read_index_i] : '0;
        end else begin
            read_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            search_valid_o <= 1'b0;
            search_index_o <= '0;
            search_multi_o <= 1'b0;
        end else if (search_enable_i) begin
            search_valid_o <= w_any;
            search_index_o <= w_idx;
            search_multi_o <= w_multi;
        end else begin
            search_valid_o <= 1'b0;
            search_multi_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cam_param.sv
// Scoreboard bench for cam_param: directed plan plus random traffic.
// Honours CAM_TERNARY_EN when the design is built with it.
module tb_cam_param;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int IDX_W  = 5;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              read_enable_i;
    logic [IDX_W-1:0]  read_index_i;
    logic              write_enable_i;
    logic [IDX_W-1:0]  write_index_i;
    logic [DATA_W-1:0] write_data_i;
    logic              inval_enable_i;
    logic [IDX_W-1:0]  inval_index_i;
    logic              search_enable_i;
    logic [DATA_W-1:0] search_data_i;
`ifdef CAM_TERNARY_EN
    logic [DATA_W-1:0] search_mask_i;
`endif
    logic              read_valid_o;
    logic [DATA_W-1:0] read_value_o;
    logic              search_valid_o;
    logic [IDX_W-1:0]  search_index_o;
    logic              search_multi_o;
    logic [IDX_W:0]    count_o;

    cam_param #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .read_enable_i   (read_enable_i),
        .read_index_i    (read_index_i),
        .write_enable_i  (write_enable_i),
        .write_index_i   (write_index_i),
        .write_data_i    (write_data_i),
        .inval_enable_i  (inval_enable_i),
        .inval_index_i   (inval_index_i),
        .search_enable_i (search_enable_i),
        .search_data_i   (search_data_i),
`ifdef CAM_TERNARY_EN
        .search_mask_i   (search_mask_i),
`endif
        .read_valid_o    (read_valid_o),
        .read_value_o    (read_value_o),
        .search_valid_o  (search_valid_o),
        .search_index_o  (search_index_o),
        .search_multi_o  (search_multi_o),
        .count_o         (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rv;
        logic [31:0] rval;
        logic        sv;
        logic [4:0]  sidx;
        logic        sm;
        logic [5:0]  cnt;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] md [DEPTH];
    bit          mv [DEPTH];
    logic [31:0] last_rval = '0;
    logic [4:0]  last_sidx = '0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk_i) begin
        #1;
        if (mon_en) begin
            if (q.size() == 0) begin
                chk("scoreboard_underflow", 64'd1, 64'd0);
            end else begin
                mon_e = q.pop_front();
                chk("read_valid", 64'(read_valid_o), 64'(mon_e.rv));
                chk("read_value", 64'(read_value_o), 64'(mon_e.rval));
                chk("search_valid", 64'(search_valid_o), 64'(mon_e.sv));
                chk("search_index", 64'(search_index_o), 64'(mon_e.sidx));
                chk("search_multi", 64'(search_multi_o), 64'(mon_e.sm));
                chk("count", 64'(count_o), 64'(mon_e.cnt));
            end
        end
    end

    // Called at a falling edge: drive, predict from the model, advance.
    task automatic cyc(input bit re, input int ri,
                       input bit we, input int wi, input logic [31:0] wd,
                       input bit ie, input int ii,
                       input bit se, input logic [31:0] sd,
                       input logic [31:0] sm);
        exp_t        e;
        int          n;
        int          first;
        int          cnt;
        logic [31:0] msk;
        read_enable_i   = re;
        read_index_i    = ri[4:0];
        write_enable_i  = we;
        write_index_i   = wi[4:0];
        write_data_i    = wd;
        inval_enable_i  = ie;
        inval_index_i   = ii[4:0];
        search_enable_i = se;
        search_data_i   = sd;
`ifdef CAM_TERNARY_EN
        search_mask_i   = sm;
        msk             = sm;
`else
        msk             = '0;
`endif
        e.rv   = re && mv[ri];
        e.rval = re ? (mv[ri] ? md[ri] : 32'h0) : last_rval;
        last_rval = e.rval;
        n = 0;
        first = 0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (mv[i] && (((md[i] ^ sd) & ~msk) == 32'h0)) begin
                n++;
                first = i;
            end
        end
        e.sv   = se && (n > 0);
        e.sidx = se ? first[4:0] : last_sidx;
        last_sidx = e.sidx;
        e.sm   = se && (n >= 2);
        if (ie) mv[ii] = 1'b0;
        if (we) begin
            mv[wi] = 1'b1;
            md[wi] = wd;
        end
        cnt = 0;
        for (int i = 0; i < DEPTH; i++) cnt += int'(mv[i]);
        e.cnt = cnt[5:0];
        q.push_back(e);
        @(negedge clk_i);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0000;
            1:       return 32'hDEAD_BEEF;
            2:       return 32'h1234_5678;
            default: return 32'h0000_FFFF;
        endcase
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_read_valid"}, 64'(read_valid_o), 64'd0);
        chk({tag, "_read_value"}, 64'(read_value_o), 64'd0);
        chk({tag, "_search_valid"}, 64'(search_valid_o), 64'd0);
        chk({tag, "_search_index"}, 64'(search_index_o), 64'd0);
        chk({tag, "_search_multi"}, 64'(search_multi_o), 64'd0);
        chk({tag, "_count"}, 64'(count_o), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        read_enable_i = 0; read_index_i = 0;
        write_enable_i = 0; write_index_i = 0; write_data_i = 0;
        inval_enable_i = 0; inval_index_i = 0;
        search_enable_i = 0; search_data_i = 0;
`ifdef CAM_TERNARY_EN
        search_mask_i = 0;
`endif
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_zero("reset");
        rst_i  = 1'b1;
        mon_en = 1'b1;

        cyc(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 9, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
        cyc(0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
        cyc(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 7, 32'h12345678, 0, 0, 1, 32'h12345678, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678, 0);
        cyc(0, 0, 0, 0, 0, 1, 20, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            cyc(0, 0, 1, i, 32'h1000_0000 + i, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 32'hCAFE_0000, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 4, 32'h4444_4444, 1, 4, 0, 0, 0);
        cyc(1, 4, 1, 6, 32'h6666_6666, 1, 8, 1, 32'h4444_4444, 0);
        cyc(1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef CAM_TERNARY_EN
        cyc(0, 0, 1, 2, 32'hAB00_0011, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hAB00_00FF, 32'h0000_00FF);
`endif
        cyc(1, 4, 0, 0, 0, 0, 0, 1, 32'h4444_4444, 0);

        mon_en = 1'b0;
        rst_i  = 1'b0;
        #1;
        chk_zero("midreset");
        q.delete();
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
        last_rval = '0;
        last_sidx = '0;
        @(negedge clk_i);
        rst_i  = 1'b1;
        mon_en = 1'b1;
        cyc(1, 4, 0, 0, 0, 0, 0, 1, 32'h4444_4444, 0);

        for (int n = 0; n < 2000; n++) begin
            cyc($urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
                $urandom_range(0, 2) != 0, $urandom_range(0, DEPTH - 1),
                pick(),
                $urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1),
                $urandom_range(0, 1), pick(),
                ($urandom_range(0, 3) == 0) ? 32'h0000_00FF : 32'h0);
        end

        mon_en = 1'b0;
        chk("queue_drain", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_param.md
Name: cam_param

Overview:
- Parametrised content-addressable memory; next generation of the fixed 32x32 CAM.
- Generalised entry width and depth. Adds per-entry valid bits, explicit invalidate, a multi-match flag and an occupancy counter.
- Sits behind the CAM bench interface and is driven by the bench clocking block; all outputs are registered.

Parameters:
- DATA_W, 32, entry and search key width in bits
- DEPTH, 32, number of entries; must be a power of 2, minimum 2
- IDX_W, $clog2(DEPTH), index width (derived; do not override)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- read_enable_i  in  1  read request
- read_index_i  in  IDX_W  read address
- write_enable_i  in  1  write request; sets the entry's valid bit
- write_index_i  in  IDX_W  write address
- write_data_i  in  DATA_W  write data
- inval_enable_i  in  1  invalidate request
- inval_index_i  in  IDX_W  entry to invalidate
- search_enable_i  in  1  search request
- search_data_i  in  DATA_W  search key
- read_valid_o  out  1  read result valid (entry was valid)
- read_value_o  out  DATA_W  read data
- search_valid_o  out  1  at least one valid entry matched
- search_index_o  out  IDX_W  lowest matching index
- search_multi_o  out  1  two or more entries matched
- count_o  out  IDX_W+1  number of valid entries

Behaviour:
- Reset (rst_i=0, async): all valid bits cleared; every output 0; count_o=0. Entry data is not reset.
- Read: 1-cycle latency.
  - Cycle after read_enable_i: read_valid_o = valid[idx] and read_value_o = data[idx].
  - Invalid entry: read_valid_o=0 and read_value_o=0.
  - No request: read_valid_o=0; read_value_o holds its last value.
- Write: commits at the clock edge; sets valid[idx]. Overwriting a valid entry does not change count_o.
- Invalidate: clears valid[idx] at the clock edge. Invalidating an already-invalid entry is a no-op; count unchanged.
- Search: 1-cycle latency.
  - match[i] = valid[i] && data[i]==key.
  - search_valid_o = |match.
  - search_index_o = lowest set index of match, 0 if none.
  - search_multi_o = popcount(match)>=2.
  - No request: search_valid_o=0 and search_multi_o=0; search_index_o holds.
- Simultaneous events in the same cycle:
  - Read or search vs write/invalidate: read and search see pre-edge contents (old data, old valid).
  - Write and invalidate to the same index: write wins; entry ends valid with new data.
  - Write and invalidate to different indices: both take effect; count_o changes by (+1 if write target was invalid) + (-1 if inval target was valid).
- count_o: updated at the same edge as the valid bits. Range 0..DEPTH (hence IDX_W+1 bits); it never wraps.
- All request types may be asserted together every cycle; there is no back-pressure.
- Reset asserted mid-operation: in-flight read/search results are discarded; outputs go to 0 immediately.

Optional Feature:
- Macro CAM_TERNARY_EN.
- Defined: adds port search_mask_i (in, DATA_W); bits set to 1 are don't-care. match[i] = valid[i] && ((data[i]^key)&~mask)==0.
- Undefined: port absent; exact match only.

Decomposition:
- Package cam_pkg:
  - default DATA_W/DEPTH localparams;
  - typedef cam_req_t (enable, index, data);
  - typedef cam_rsp_t (valid, index, multi);
  - function for lowest-set-bit index.
- One sub-module, cam_prio_enc: DEPTH-bit match vector -> any, lowest index, multi. Purely combinational; its outputs are registered in cam_param.

Test Plan:
- Reset, then read idx 5 -> next cycle read_valid_o=0, read_value_o=0; count_o=0.
- Write 0xDEADBEEF@3 and 0xDEADBEEF@9, then search 0xDEADBEEF -> next cycle search_valid_o=1, search_index_o=3, search_multi_o=1, count_o=2.
- Invalidate idx 3, then search 0xDEADBEEF -> search_index_o=9, search_multi_o=0, count_o=1; read idx 3 -> read_valid_o=0.
- Same cycle: write 0x12345678@7 and search 0x12345678 -> search_valid_o=0. Repeat the search next cycle -> search_valid_o=1, search_index_o=7.
- Fill all DEPTH entries -> count_o=32; overwrite idx 0 -> count stays 32. Same cycle write@4 and inval@4 -> entry 4 valid, count unchanged.
- With CAM_TERNARY_EN: entry 0xAB00_0011@2, key 0xAB00_00FF, mask 0x0000_00FF -> search_valid_o=1, search_index_o=2.
